vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 48 ++++
 rtl/vram_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: the CPU Avalon-MM slave port, the VGA fetch port and the single-port RAM.
// The arbiter takes the slave modport; the CPU, the VGA and the RAM environment take the master modport.
// Handshakes:
//   Avalon: a transfer completes in the cycle where avl_read or avl_write is high and avl_waitrequest is low.
//     The master holds its strobe, address and data stable until that cycle.
//   VGA: vid_req is offered each cycle with no backpressure. The request either returns data one cycle later
//     (vid_valid) or is dropped and flagged by a same-cycle vid_miss pulse.
interface vram_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read;
  logic              avl_write;
  logic [31:0]       avl_writedata;
  logic [3:0]        avl_byteenable;
  logic [31:0]       avl_readdata;
  logic              avl_waitrequest;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [31:0]       vid_data;
  logic              vid_miss;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_readdata, avl_waitrequest,
    input  vid_req, vid_addr,
    output vid_valid, vid_data, vid_miss,
    output ram_addr, ram_we, ram_be, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_readdata, avl_waitrequest,
    output vid_req, vid_addr,
    input  vid_valid, vid_data, vid_miss,
    input  ram_addr, ram_we, ram_be, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port VRAM between VGA scan-out (default priority) and a CPU Avalon-MM port.
// After STARVE_MAX consecutive denials, the CPU is forced a slot.
module vram_arbiter #(
  parameter  int ADDR_W     = 11,
  parameter  int STARVE_MAX = 3,
  localparam int CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  vram_arbiter_if.slave    bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t            state;
  logic [CNT_W-1:0]  deny_cnt;
  logic [31:0]       readdata_q;
  logic              vid_valid_q;
  logic [ADDR_W-1:0] addr_q;

  logic              cpu_wr;
  logic              cpu_rd;
  logic              pending;
  logic              starved;
  logic              cpu_grant;
  logic              vid_grant;
  logic              wr_grant;
  logic [ADDR_W-1:0] ram_addr_c;

  // Grants are gated by reset so that the RAM sees no write while RESET_N is low.
  always_comb begin
    cpu_wr     = bus.avl_write;
    cpu_rd     = bus.avl_read && !bus.avl_write;
    pending    = (state == IDLE) && (cpu_wr || cpu_rd);
    starved    = (deny_cnt == STARVE_LIM);
    cpu_grant  = RESET_N && pending && (!bus.vid_req || starved);
    vid_grant  = RESET_N && bus.vid_req && !cpu_grant;
    wr_grant   = cpu_grant && cpu_wr;
    ram_addr_c = addr_q;
    if (vid_grant) begin
      ram_addr_c = bus.vid_addr;
    end else if (cpu_grant) begin
      ram_addr_c = bus.avl_address;
    end
  end

  always_comb begin
    bus.ram_addr  = ram_addr_c;
    bus.ram_we    = wr_grant;
    bus.ram_be    = wr_grant ? bus.avl_byteenable : 4'hF;
    bus.ram_wdata = bus.avl_writedata;
    bus.vid_miss  = bus.vid_req && cpu_grant;
    bus.vid_valid = vid_valid_q;
    bus.vid_data  = vid_valid_q ? bus.ram_rdata : 32'h0;
    bus.avl_readdata = readdata_q;
    case (state)
      IDLE:    bus.avl_waitrequest = pending && !wr_grant;
      RD_WAIT: bus.avl_waitrequest = 1'b1;
      RD_DONE: bus.avl_waitrequest = 1'b0;
      default: bus.avl_waitrequest = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      deny_cnt    <= '0;
      readdata_q  <= '0;
      vid_valid_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      addr_q      <= ram_addr_c;
      vid_valid_q <= vid_grant;
      // A pending CPU denial implies the counter is below STARVE_MAX, so it cannot overflow.
      if (cpu_grant) begin
        deny_cnt <= '0;
      end else if (pending) begin
        deny_cnt <= deny_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (cpu_grant && cpu_rd) begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          readdata_q <= bus.ram_rdata;
          state      <= RD_DONE;
        end
        RD_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_cnt   = deny_cnt;

endmodule
